// File: rtl/potential_adder.sv
// Membrane-potential update stage. Combines the decayed potential with the
// summed synaptic input under the LIF, Izhikevich or QLIF model, compares the
// result against the threshold and reports spike / new potential / done.
// Model parameters live in local registers written through the load port.
// All products come from one shared shift-add multiplier (low WIDTH bits).
module potential_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             time_step,
  input  logic             load,
  input  logic [2:0]       init_mode,
  input  logic [WIDTH-1:0] input_weight,
  input  logic [WIDTH-1:0] decayed_potential,
  input  logic [1:0]       model,
  output logic [WIDTH-1:0] final_potential,
  output logic             done,
  output logic             spike
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic signed [WIDTH-1:0] DEF_A  = WIDTH'(5);
  localparam logic signed [WIDTH-1:0] DEF_B  = WIDTH'(51);
  localparam logic signed [WIDTH-1:0] DEF_C  = -WIDTH'(65);
  localparam logic signed [WIDTH-1:0] DEF_D  = WIDTH'(8);
  localparam logic signed [WIDTH-1:0] DEF_VT = WIDTH'(30);
  localparam logic signed [WIDTH-1:0] DEF_U  = '0;
  localparam logic signed [WIDTH-1:0] K140   = WIDTH'(140);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Izhikevich sub-steps: v*v, then B*v, then A*(((B*v)>>>8) - U)
  typedef enum logic [1:0] {PH_SQ, PH_BV, PH_AU} phase_t;

  state_t state_reg;
  phase_t phase_reg;

  logic signed [WIDTH-1:0] a_reg, b_reg, c_reg, d_reg, vt_reg, u_reg;
  logic signed [WIDTH-1:0] v_reg, i_reg, sq_reg;
  logic [1:0]              model_reg;

  logic signed [WIDTH-1:0] mcand_reg, mplier_reg, prod_reg;
  logic [CNT_W-1:0]        mul_cnt_reg;

  logic signed [WIDTH-1:0] final_potential_reg;
  logic                    spike_reg, done_reg;

  logic                    is_izh, is_qlif;
  logic signed [WIDTH-1:0] p_lif, p_qlif, p_izh, un_next, au_operand;

  assign is_izh  = (model_reg == 2'b01);
  assign is_qlif = (model_reg == 2'b10);

  // Candidate potentials and recovery update from latched operands and the
  // current multiplier result.
  always_comb begin
    p_lif      = v_reg + i_reg;
    p_qlif     = v_reg + (prod_reg >>> 4) + i_reg;
    p_izh      = v_reg + (sq_reg >>> 5) + ((v_reg <<< 2) + v_reg) + K140 - u_reg + i_reg;
    un_next    = u_reg + (prod_reg >>> 8);
    au_operand = (prod_reg >>> 8) - u_reg;
  end

  // Control FSM, parameter registers, shared multiplier and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      phase_reg           <= PH_SQ;
      a_reg               <= DEF_A;
      b_reg               <= DEF_B;
      c_reg               <= DEF_C;
      d_reg               <= DEF_D;
      vt_reg              <= DEF_VT;
      u_reg               <= DEF_U;
      v_reg               <= '0;
      i_reg               <= '0;
      sq_reg              <= '0;
      model_reg           <= 2'b00;
      mcand_reg           <= '0;
      mplier_reg          <= '0;
      prod_reg            <= '0;
      mul_cnt_reg         <= '0;
      final_potential_reg <= '0;
      spike_reg           <= 1'b0;
      done_reg            <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (load) begin
            case (init_mode)
              3'b000: begin
                a_reg  <= DEF_A;
                b_reg  <= DEF_B;
                c_reg  <= DEF_C;
                d_reg  <= DEF_D;
                vt_reg <= DEF_VT;
                u_reg  <= DEF_U;
              end
              3'b001:  a_reg  <= input_weight;
              3'b010:  b_reg  <= input_weight;
              3'b011:  c_reg  <= input_weight;
              3'b100:  d_reg  <= input_weight;
              3'b101:  vt_reg <= input_weight;
              3'b110:  u_reg  <= input_weight;
              default: ;
            endcase
          end else if (time_step) begin
            v_reg       <= decayed_potential;
            i_reg       <= input_weight;
            model_reg   <= model;
            spike_reg   <= 1'b0;
            phase_reg   <= PH_SQ;
            // v*v is needed by both nonlinear models, so start it right away
            mcand_reg   <= decayed_potential;
            mplier_reg  <= decayed_potential;
            prod_reg    <= '0;
            mul_cnt_reg <= CNT_W'(WIDTH);
            state_reg   <= CALC;
          end
        end

        CALC: begin
          if (!is_izh && !is_qlif) begin
            spike_reg           <= (p_lif >= vt_reg);
            final_potential_reg <= (p_lif >= vt_reg) ? '0 : p_lif;
            state_reg           <= DONE;
          end else if (mul_cnt_reg != '0) begin
            if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
            mcand_reg   <= mcand_reg << 1;
            mplier_reg  <= mplier_reg >> 1;
            mul_cnt_reg <= mul_cnt_reg - 1'b1;
          end else if (is_qlif) begin
            spike_reg           <= (p_qlif >= vt_reg);
            final_potential_reg <= (p_qlif >= vt_reg) ? '0 : p_qlif;
            state_reg           <= DONE;
          end else begin
            case (phase_reg)
              PH_SQ: begin
                sq_reg      <= prod_reg;
                mcand_reg   <= b_reg;
                mplier_reg  <= v_reg;
                prod_reg    <= '0;
                mul_cnt_reg <= CNT_W'(WIDTH);
                phase_reg   <= PH_BV;
              end
              PH_BV: begin
                mcand_reg   <= a_reg;
                mplier_reg  <= au_operand;
                prod_reg    <= '0;
                mul_cnt_reg <= CNT_W'(WIDTH);
                phase_reg   <= PH_AU;
              end
              default: begin
                spike_reg <= (p_izh >= vt_reg);
                if (p_izh >= vt_reg) begin
                  final_potential_reg <= c_reg;
                  u_reg               <= un_next + d_reg;
                end else begin
                  final_potential_reg <= p_izh;
                  u_reg               <= un_next;
                end
                state_reg <= DONE;
              end
            endcase
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign final_potential = final_potential_reg;
  assign spike           = spike_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_potential_adder.sv
// Directed bench for potential_adder: reset, parameter loads, each neuron
// model, busy-time stimulus, default restore, wrap-around and mid-update reset.
module tb_potential_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        time_step;
  logic        load;
  logic [2:0]  init_mode;
  logic [31:0] input_weight;
  logic [31:0] decayed_potential;
  logic [1:0]  model;
  logic [31:0] final_potential;
  logic        done;
  logic        spike;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  potential_adder #(.WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .time_step         (time_step),
    .load              (load),
    .init_mode         (init_mode),
    .input_weight      (input_weight),
    .decayed_potential (decayed_potential),
    .model             (model),
    .final_potential   (final_potential),
    .done              (done),
    .spike             (spike)
  );

  // Pulse time_step for one cycle and wait (bounded) for done.
  task automatic run_step(input logic [1:0] m, input logic [31:0] v, input logic [31:0] i,
                          input int limit, output int cycles);
    model = m; decayed_potential = v; input_weight = i; time_step = 1'b1;
    @(posedge clk); #1;
    time_step = 1'b0;
    cycles = 0;
    while (!done && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_load(input logic [2:0] mode, input logic [31:0] val);
    load = 1'b1; init_mode = mode; input_weight = val;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (final_potential !== 32'd0 || spike !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: fp=%0d spike=%b done=%b, required 0/0/0", final_potential, spike, done);
    end
    $display("reset: fp=%0d spike=%b done=%b", final_potential, spike, done);
  endtask

  task automatic test_param_load();
    logic [31:0] vals [6] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd5};
    for (int k = 0; k < 6; k++) begin
      do_load(3'(k + 1), vals[k]);
      n_checks++;
      if (done !== 1'b0 || final_potential !== 32'd0 || spike !== 1'b0) begin
        n_fail++;
        $display("FAIL load_%0d: done=%b fp=%0d spike=%b, required 0/0/0", k + 1, done, final_potential, spike);
      end
      $display("load mode=%0d val=%0d", k + 1, vals[k]);
    end
  endtask

  task automatic test_lif();
    int cyc;
    run_step(2'b00, 32'd25, 32'd25, 10, cyc);
    n_checks++;
    if (cyc !== 2 || spike !== 1'b1 || final_potential !== 32'd0) begin
      n_fail++;
      $display("FAIL lif_spike: cycles=%0d spike=%b fp=%0d, required 2/1/0", cyc, spike, final_potential);
    end
    $display("lif v=25 I=25: cycles=%0d spike=%b fp=%0d", cyc, spike, final_potential);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (spike !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL lif_hold: spike=%b done=%b, required 1/0", spike, done);
    end
  endtask

  task automatic test_izhikevich();
    int cyc;
    run_step(2'b01, 32'd35, 32'd25, 120, cyc);
    n_checks++;
    if (!done || spike !== 1'b1 || final_potential !== 32'd30) begin
      n_fail++;
      $display("FAIL izh_step1: done=%b cycles=%0d spike=%b fp=%0d, required 1/<=120/1/30", done, cyc, spike, final_potential);
    end
    $display("izh v=35 I=25: cycles=%0d spike=%b fp=%0d", cyc, spike, final_potential);
  endtask

  // Follow-up Izhikevich step (p = 140-44 = 96) with a time_step and a
  // VT=1000 load landing mid-CALC; both must be dropped.
  task automatic test_busy();
    int cyc = 0;
    int extra = 0;
    model = 2'b01; decayed_potential = 32'd0; input_weight = 32'd0; time_step = 1'b1;
    @(posedge clk); #1;
    time_step = 1'b0;
    while (!done && cyc < 120) begin
      if (cyc == 5) begin
        time_step = 1'b1; load = 1'b1; init_mode = 3'b101; input_weight = 32'd1000;
      end else begin
        time_step = 1'b0; load = 1'b0; input_weight = 32'd0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    time_step = 1'b0; load = 1'b0;
    n_checks++;
    if (!done || spike !== 1'b1 || final_potential !== 32'd30) begin
      n_fail++;
      $display("FAIL busy_izh: done=%b spike=%b fp=%0d, required 1/1/30", done, spike, final_potential);
    end
    $display("izh busy v=0 I=0: cycles=%0d spike=%b fp=%0d", cyc, spike, final_potential);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_extra_done: got %0d done pulses, required 0", extra);
    end
  endtask

  task automatic test_qlif();
    int cyc;
    run_step(2'b10, 32'd10, 32'd30, 40, cyc);
    n_checks++;
    if (!done || spike !== 1'b0 || final_potential !== 32'd46) begin
      n_fail++;
      $display("FAIL qlif: done=%b cycles=%0d spike=%b fp=%0d, required 1/<=40/0/46", done, cyc, spike, final_potential);
    end
    $display("qlif v=10 I=30: cycles=%0d spike=%b fp=%0d", cyc, spike, final_potential);
  endtask

  task automatic test_defaults();
    int cyc;
    do_load(3'b000, 32'd0);
    run_step(2'b00, 32'd20, 32'd10, 10, cyc);
    n_checks++;
    if (cyc !== 2 || spike !== 1'b1 || final_potential !== 32'd0) begin
      n_fail++;
      $display("FAIL defaults_lif: cycles=%0d spike=%b fp=%0d, required 2/1/0", cyc, spike, final_potential);
    end
    $display("defaults lif v=20 I=10: spike=%b fp=%0d", spike, final_potential);
    run_step(2'b11, 32'd10, 32'd5, 10, cyc);
    n_checks++;
    if (cyc !== 2 || spike !== 1'b0 || final_potential !== 32'd15) begin
      n_fail++;
      $display("FAIL lif_nospike: cycles=%0d spike=%b fp=%0d, required 2/0/15", cyc, spike, final_potential);
    end
    $display("lif(model 11) v=10 I=5: spike=%b fp=%0d", spike, final_potential);
  endtask

  task automatic test_wrap();
    int cyc;
    run_step(2'b00, 32'h7fff_ffff, 32'd1, 10, cyc);
    n_checks++;
    if (!done || spike !== 1'b0 || final_potential !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL wrap: spike=%b fp=%h, required 0/80000000", spike, final_potential);
    end
    $display("lif wrap: spike=%b fp=%h", spike, final_potential);
  endtask

  // Default params: v=-70 gives p=-127, U=-1; again p=-126, U=-2;
  // then v=0 gives p=142 -> spike, fp=C=-65.
  task automatic test_izh_defaults();
    int cyc;
    logic [31:0] vv  [3] = '{-32'sd70, -32'sd70, 32'd0};
    logic [31:0] efp [3] = '{-32'sd127, -32'sd126, -32'sd65};
    logic        esp [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      run_step(2'b01, vv[k], 32'd0, 120, cyc);
      n_checks++;
      if (!done || spike !== esp[k] || final_potential !== efp[k]) begin
        n_fail++;
        $display("FAIL izh_def_%0d: done=%b spike=%b fp=%0d, required 1/%b/%0d", k, done, spike,
                 $signed(final_potential), esp[k], $signed(efp[k]));
      end
      $display("izh default step %0d: spike=%b fp=%0d", k, spike, $signed(final_potential));
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen = 0;
    do_load(3'b101, 32'd1000);
    model = 2'b01; decayed_potential = 32'd35; input_weight = 32'd25; time_step = 1'b1;
    @(posedge clk); #1;
    time_step = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (final_potential !== 32'd0 || spike !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: fp=%0d spike=%b done=%b, required 0/0/0", final_potential, spike, done);
    end
    for (int k = 0; k < 130; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d done pulses, required 0", seen);
    end
    run_step(2'b00, 32'd20, 32'd10, 10, cyc);
    n_checks++;
    if (cyc !== 2 || spike !== 1'b1 || final_potential !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_defaults: cycles=%0d spike=%b fp=%0d, required 2/1/0", cyc, spike, final_potential);
    end
    $display("after mid reset lif v=20 I=10: spike=%b fp=%0d", spike, final_potential);
  endtask

  initial begin
    rst = 1'b1; time_step = 1'b0; load = 1'b0; init_mode = 3'b000;
    input_weight = '0; decayed_potential = '0; model = 2'b00;
    @(posedge clk); #1;
    test_reset();
    test_param_load();
    test_lif();
    test_izhikevich();
    test_busy();
    test_qlif();
    test_defaults();
    test_wrap();
    test_izh_defaults();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/potential_adder.md
Name: potential_adder

Overview:
- Membrane-potential update stage of the neuromorphic integration datapath.
- On each time step it combines the already-decayed potential with the summed input weight, using the selected neuron model (LIF, Izhikevich, QLIF).
- It then compares the result against the threshold and reports spike, new potential and done.
- Model parameters (A, B, C, D, VT, U) are held in internal registers and written through a load port that shares the input_weight bus.

Parameters:
- WIDTH, 32, datapath width; all values are two's-complement signed.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- time_step  in  1  one-cycle start pulse for one update; sampled only in IDLE.
- load  in  1  parameter write strobe; sampled only in IDLE.
- init_mode  in  3  parameter select when load=1:
  - 000 = restore all defaults
  - 001 = A, 010 = B, 011 = C, 100 = D
  - 101 = VT, 110 = U
  - 111 = ignored
- input_weight  in  32  on update, the synaptic input I; on load, the parameter value.
- decayed_potential  in  32  v, the decayed potential for this update.
- model  in  2  00 = LIF, 01 = Izhikevich, 10 = QLIF, 11 = treated as LIF.
- final_potential  out  32  updated potential, registered.
- done  out  1  one-cycle pulse when final_potential/spike are valid.
- spike  out  1  registered; held until the next update starts.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset effects:
  - final_potential=0, spike=0, done=0, FSM to IDLE.
  - Parameters take their defaults: A=5, B=51, C=-65, D=8, VT=30, U=0.
  - A and B are Q0.8 fractions (value/256).
- Parameter load:
  - In IDLE, load=1 writes input_weight into the register selected by init_mode on that edge.
  - Load has priority over a simultaneous time_step; that time_step is dropped.
  - Load outside IDLE is ignored.
- FSM: IDLE -> CALC (multi-cycle) -> DONE -> IDLE.
  - time_step in IDLE latches v, I and model, then enters CALC.
  - DONE drives done=1 for exactly one cycle.
  - time_step and load are ignored while not in IDLE.
- Multiplies:
  - Use one shared sequential shift-add 32x32 signed multiplier, keeping the low 32 bits of the product.
  - All right shifts are arithmetic (floor).
- LIF: p = v + I.
- QLIF: p = v + ((v*v) >>> 4) + I.
- Izhikevich:
  - p = v + ((v*v) >>> 5) + 5v + 140 - U + I, with 5v computed as (v<<2)+v.
  - Recovery: un = U + ((A * (((B*v) >>> 8) - U)) >>> 8), using the old U and the latched v.
- Spike condition: p >= VT (signed compare).
  - LIF/QLIF spike: final_potential=0.
  - Izhikevich spike: final_potential=C and U <= un + D.
  - No spike: final_potential=p; for Izhikevich, U <= un.
- Output timing:
  - final_potential and spike update on the edge entering DONE.
  - Both hold until the next accepted time_step clears spike.
- Latency, counted from the time_step edge to the done-high cycle:
  - LIF: 2 cycles.
  - QLIF: <= 40 cycles.
  - Izhikevich: <= 120 cycles.
- Overflow wraps modulo 2^32; there is no saturation.
- Reset mid-operation aborts the update: outputs return to their reset values and parameters return to defaults.

Test Plan:
- Reset check: hold rst=1 for 2 cycles -> final_potential=0, spike=0, done=0.
- Parameter loads: write A=10, B=20, C=30, D=40, VT=50, U=5 via load/init_mode 001..110 -> no done pulse, outputs unchanged.
- LIF with those params: model=00, v=25, I=25, time_step pulse -> done pulse 2 cycles later, p=50>=VT, spike=1, final_potential=0.
- Izhikevich: model=01, v=35, I=25 -> done within 120 cycles.
  - p = 35+38+175+140-5+25 = 408, spike=1, final_potential=30.
  - Internal U becomes 5-1+40 = 44.
  - A follow-up Izhikevich step with v=0, I=0 gives p = 140-44 = 96, spike=1.
- QLIF: model=10, v=10, I=30 -> p = 10+6+30 = 46 < 50, spike=0, final_potential=46, done within 40 cycles.
- Busy and default-restore:
  - time_step and load during an Izhikevich CALC -> ignored, no extra done.
  - load with init_mode=000 -> defaults restored; LIF with v=20, I=10 then gives spike=1 (30 >= 30), final_potential=0.
